// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to a 1-cycle-latency RAM,
// and buffers returned words with their PCs in a small FIFO for decode.
// Reads are credit limited, so the FIFO can never be pushed while full.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [29:0] mem_addr_o,
    output logic        mem_re_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        halt_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'd3;

    logic [31:0]   pcReq_q, pcReq_d;
    logic [31:0]   respPc_q, respPc_d;
    logic          inflight_q, inflight_d;
    logic          drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [31:0]   fifoData_q [DEPTH];
    logic [31:0]   fifoPc_q   [DEPTH];

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   occupancy;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign instr_valid_o = (count_q != '0);
    assign instr_o       = fifoData_q[rdPtr_q];
    assign instr_pc_o    = fifoPc_q[rdPtr_q];
    assign mem_addr_o    = pcReq_q[31:2];
    assign mem_re_o      = issue;

    // Handshake, credit check and next-state for PC, in-flight tracking and FIFO pointers.
    always_comb begin
        pop        = instr_valid_o & instr_ready_i;
        push       = inflight_q & ~drop_q & ~redirect_i;
        occupancy  = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        issue      = rst_n & ~halt_i & ~redirect_i & (occupancy < (CW+1)'(DEPTH));

        pcReq_d    = pcReq_q;
        respPc_d   = respPc_q;
        inflight_d = issue;
        drop_d     = 1'b0;
        count_d    = count_q;
        rdPtr_d    = rdPtr_q;
        wrPtr_d    = wrPtr_q;

        if (redirect_i) begin
            pcReq_d = redirect_pc_i & ~32'd3;
            drop_d  = inflight_q;
            count_d = '0;
            rdPtr_d = '0;
            wrPtr_d = '0;
        end else begin
            if (issue) begin
                pcReq_d  = pcReq_q + 32'd4;
                respPc_d = pcReq_q;
            end
            if (push) begin
                wrPtr_d = nextPtr(wrPtr_q);
            end
            if (pop) begin
                rdPtr_d = nextPtr(rdPtr_q);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcReq_q    <= RESET_PC_ALIGNED;
            respPc_q   <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            count_q    <= '0;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
        end else begin
            pcReq_q    <= pcReq_d;
            respPc_q   <= respPc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
        end
    end

    // FIFO storage: captures the returning word together with the PC it was fetched from.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifoData_q[i] <= '0;
                fifoPc_q[i]   <= '0;
            end
        end else if (push) begin
            fifoData_q[wrPtr_q] <= mem_rdata_i;
            fifoPc_q[wrPtr_q]   <= respPc_q;
        end
    end

    // The credit rule guarantees a push never lands on a full FIFO without a matching pop.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && !pop && (count_q == CW'(DEPTH))));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, a wrap-around PC
// sequence on a second instance, and a randomized run against a stream model.
module tb_fetch_unit;

    logic        clk;
    logic        rstN;
    logic        halt;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        ready;

    logic [29:0] memAddr;
    logic        memRe;
    logic [31:0] memRdata;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic        instrValid;

    logic [29:0] memAddr2;
    logic        memRe2;
    logic [31:0] memRdata2;
    logic [31:0] instr2;
    logic [31:0] instrPc2;
    logic        instrValid2;

    int checks;
    int errors;

    typedef struct {
        logic        rstN;
        logic        halt;
        logic        redirect;
        logic [31:0] redirectPc;
        logic        ready;
        logic        expValid;
        logic [31:0] expInstr;
        logic [31:0] expPc;
        logic        expRe;
        logic [29:0] expAddr;
    } vector_t;

    vector_t vecs[$];

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rstN),
        .mem_addr_o    (memAddr),
        .mem_re_o      (memRe),
        .mem_rdata_i   (memRdata),
        .halt_i        (halt),
        .redirect_i    (redirect),
        .redirect_pc_i (redirectPc),
        .instr_o       (instr),
        .instr_pc_o    (instrPc),
        .instr_valid_o (instrValid),
        .instr_ready_i (ready)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dutWrap (
        .clk           (clk),
        .rst_n         (rstN),
        .mem_addr_o    (memAddr2),
        .mem_re_o      (memRe2),
        .mem_rdata_i   (memRdata2),
        .halt_i        (1'b0),
        .redirect_i    (1'b0),
        .redirect_pc_i (32'h0),
        .instr_o       (instr2),
        .instr_pc_o    (instrPc2),
        .instr_valid_o (instrValid2),
        .instr_ready_i (1'b1)
    );

    // RAM contents: the four-instruction program at words 0..3, a unique pattern elsewhere.
    function automatic logic [31:0] memWord(input logic [29:0] a);
        case (a)
            30'd0:   return 32'h0020_0093;
            30'd1:   return 32'h0030_0113;
            30'd2:   return 32'h0011_01b3;
            30'd3:   return 32'h0010_0073;
            default: return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed RAM models with one cycle of read latency; output holds when not read.
    initial begin
        memRdata  = '0;
        memRdata2 = '0;
    end
    always @(posedge clk) begin
        if (memRe)  memRdata  <= memWord(memAddr);
        if (memRe2) memRdata2 <= memWord(memAddr2);
    end

    task automatic applyStimulus(input logic r, input logic h, input logic rd,
                                 input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        rstN       = r;
        halt       = h;
        redirect   = rd;
        redirectPc = rpc;
        ready      = rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic addVec(input logic r, input logic h, input logic rd, input logic [31:0] rpc,
                          input logic rdy, input logic ev, input logic [31:0] ei,
                          input logic [31:0] ep, input logic ere, input logic [29:0] ea);
        vector_t v;
        v.rstN = r; v.halt = h; v.redirect = rd; v.redirectPc = rpc; v.ready = rdy;
        v.expValid = ev; v.expInstr = ei; v.expPc = ep; v.expRe = ere; v.expAddr = ea;
        vecs.push_back(v);
    endtask

    logic [31:0] wrapPcs [4];
    logic [31:0] expPc;
    logic [31:0] reqPc;
    logic [31:0] prevInstr;
    logic [31:0] prevPc;
    logic        prevHold;
    int          streak;
    logic        rHalt, rRedir, rReady;
    logic [31:0] rPc;

    initial begin
        checks = 0;
        errors = 0;
        rstN = 1'b0; halt = 1'b0; redirect = 1'b0; redirectPc = '0; ready = 1'b0;

        // Wrap-around start PC on the second instance.
        wrapPcs[0] = 32'hFFFF_FFF8;
        wrapPcs[1] = 32'hFFFF_FFFC;
        wrapPcs[2] = 32'h0000_0000;
        wrapPcs[3] = 32'h0000_0004;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            if (k == 0) begin
                checkOutput("wrapFirstAddr", {2'b0, memAddr2}, 32'h3FFF_FFFE);
                checkOutput("wrapFirstRe", {31'b0, memRe2}, 32'd1);
            end
            checkOutput("wrapValid", {31'b0, instrValid2}, (k >= 2) ? 32'd1 : 32'd0);
            if (k >= 2) begin
                checkOutput("wrapPc", instrPc2, wrapPcs[k-2]);
                checkOutput("wrapInstr", instr2, memWord(wrapPcs[k-2][31:2]));
            end
        end

        // Directed table: reset, backpressure, redirect with a read in flight, halt, mid-run reset.
        addVec(0,0,0,32'h0,  0, 0,32'h0,      32'h0,   0,30'h0);
        addVec(1,0,0,32'h0,  0, 0,32'h0,      32'h0,   1,30'h0);
        addVec(1,0,0,32'h0,  0, 0,32'h0,      32'h0,   1,30'h1);
        addVec(1,0,0,32'h0,  0, 1,memWord(0), 32'h0,   0,30'h2);
        addVec(1,0,0,32'h0,  0, 1,memWord(0), 32'h0,   0,30'h2);
        addVec(1,0,0,32'h0,  0, 1,memWord(0), 32'h0,   0,30'h2);
        addVec(1,0,0,32'h0,  1, 1,memWord(0), 32'h0,   1,30'h2);
        addVec(1,0,0,32'h0,  1, 1,memWord(1), 32'h4,   1,30'h3);
        addVec(1,0,0,32'h0,  1, 1,memWord(2), 32'h8,   1,30'h4);
        addVec(1,0,0,32'h0,  1, 1,memWord(3), 32'hC,   1,30'h5);
        addVec(1,0,0,32'h0,  1, 1,memWord(4), 32'h10,  1,30'h6);
        addVec(1,0,1,32'h103,0, 1,memWord(5), 32'h14,  0,30'h7);
        addVec(1,0,0,32'h0,  1, 0,32'h0,      32'h0,   1,30'h40);
        addVec(1,0,0,32'h0,  1, 0,32'h0,      32'h0,   1,30'h41);
        addVec(1,0,0,32'h0,  1, 1,memWord(30'h40), 32'h100, 1,30'h42);
        addVec(1,0,0,32'h0,  1, 1,memWord(30'h41), 32'h104, 1,30'h43);
        addVec(1,1,0,32'h0,  1, 1,memWord(30'h42), 32'h108, 0,30'h44);
        addVec(1,1,0,32'h0,  1, 1,memWord(30'h43), 32'h10C, 0,30'h44);
        addVec(1,1,0,32'h0,  1, 0,32'h0,      32'h0,   0,30'h44);
        addVec(1,1,0,32'h0,  1, 0,32'h0,      32'h0,   0,30'h44);
        addVec(1,1,0,32'h0,  1, 0,32'h0,      32'h0,   0,30'h44);
        addVec(1,0,0,32'h0,  1, 0,32'h0,      32'h0,   1,30'h44);
        addVec(1,0,0,32'h0,  1, 0,32'h0,      32'h0,   1,30'h45);
        addVec(1,0,0,32'h0,  1, 1,memWord(30'h44), 32'h110, 1,30'h46);
        addVec(1,0,0,32'h0,  1, 1,memWord(30'h45), 32'h114, 1,30'h47);
        addVec(0,0,0,32'h0,  0, 0,32'h0,      32'h0,   0,30'h0);
        addVec(1,0,0,32'h0,  1, 0,32'h0,      32'h0,   1,30'h0);
        addVec(1,0,0,32'h0,  0, 0,32'h0,      32'h0,   1,30'h1);
        addVec(1,0,0,32'h0,  1, 1,memWord(0), 32'h0,   1,30'h2);
        addVec(1,0,0,32'h0,  0, 1,memWord(1), 32'h4,   0,30'h3);
        addVec(1,0,0,32'h0,  1, 1,memWord(1), 32'h4,   1,30'h3);
        addVec(1,0,0,32'h0,  1, 1,memWord(2), 32'h8,   1,30'h4);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rstN, vecs[i].halt, vecs[i].redirect,
                          vecs[i].redirectPc, vecs[i].ready);
            checkOutput($sformatf("vec%0d.valid", i), {31'b0, instrValid}, {31'b0, vecs[i].expValid});
            checkOutput($sformatf("vec%0d.re", i), {31'b0, memRe}, {31'b0, vecs[i].expRe});
            checkOutput($sformatf("vec%0d.addr", i), {2'b0, memAddr}, {2'b0, vecs[i].expAddr});
            if (vecs[i].expValid || !vecs[i].rstN) begin
                checkOutput($sformatf("vec%0d.instr", i), instr, vecs[i].expInstr);
                checkOutput($sformatf("vec%0d.pc", i), instrPc, vecs[i].expPc);
            end
        end

        // Randomized run: delivered words must form the sequential PC stream from the
        // latest target, fetches must be contiguous, and a stalled head must hold.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        expPc    = 32'h0;
        reqPc    = 32'h0;
        prevHold = 1'b0;
        prevInstr = '0;
        prevPc   = '0;
        streak   = 0;
        for (int c = 0; c < 3000; c++) begin
            rReady = ($urandom_range(0, 3) != 0);
            rHalt  = ($urandom_range(0, 9) == 0);
            rRedir = ($urandom_range(0, 19) == 0);
            rPc    = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 63));
            applyStimulus(1'b1, rHalt, rRedir, rPc, rReady);

            if (rHalt || rRedir) begin
                checkOutput("rndReBlocked", {31'b0, memRe}, 32'd0);
            end
            if (memRe) begin
                checkOutput("rndFetchAddr", {2'b0, memAddr}, {2'b0, reqPc[31:2]});
                reqPc = reqPc + 32'd4;
            end
            if (prevHold) begin
                checkOutput("rndHoldValid", {31'b0, instrValid}, 32'd1);
                checkOutput("rndHoldInstr", instr, prevInstr);
                checkOutput("rndHoldPc", instrPc, prevPc);
            end
            streak = (rHalt || rRedir) ? 0 : streak + 1;
            if (streak >= 3) begin
                checkOutput("rndLive", {31'b0, instrValid}, 32'd1);
            end
            if (instrValid && rReady) begin
                checkOutput("rndPopPc", instrPc, expPc);
                checkOutput("rndPopInstr", instr, memWord(expPc[31:2]));
                expPc = expPc + 32'd4;
            end
            prevHold  = instrValid && !rReady && !rRedir;
            prevInstr = instr;
            prevPc    = instrPc;
            if (rRedir) begin
                expPc = rPc & ~32'd3;
                reqPc = rPc & ~32'd3;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
